// File: rtl/com_tx_responder.sv
`default_nettype none
// ============================================================================
// Module   : com_tx_responder
// Purpose  : Responder end of the Com write handshake. Sends each accepted
//            byte as an 8N1 frame on TxD, answers with NewCom or ComEnd.
// Revision : 1.0
// ============================================================================
module com_tx_responder #(
  parameter int CLK_DIV = 16,
  parameter int MSG_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Write,
  input  logic [7:0] Data,
  output logic       TxD,
  output logic       NewCom,
  output logic       ComEnd,
  output logic       Busy,
  output logic       Overrun
);

  localparam int                BAUD_W    = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [7:0]        MSG_LAST  = 8'(MSG_LEN);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        byte_q, byte_d;
  logic              txd_q, txd_d;
  logic              newcom_q, newcom_d;
  logic              comend_q, comend_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      txd_q     <= 1'b1;
      newcom_q  <= 1'b0;
      comend_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      txd_q     <= txd_d;
      newcom_q  <= newcom_d;
      comend_q  <= comend_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    newcom_d  = 1'b0;
    // Only IDLE (including the NewCom cycle) can take a byte.
    overrun_d = Write && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (Write) begin
          shift_d = Data;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          byte_d = byte_q + 8'd1;
          if (byte_d == MSG_LAST) begin
            state_d = DONE;
          end else begin
            state_d  = IDLE;
            newcom_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line level follows the state being entered so TxD stays registered.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
    busy_d   = (state_d == START) || (state_d == DATA) || (state_d == STOP);
    comend_d = (state_d == DONE);
  end

  assign TxD     = txd_q;
  assign NewCom  = newcom_q;
  assign ComEnd  = comend_q;
  assign Busy    = busy_q;
  assign Overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_com_tx_responder.sv
`default_nettype none
// Directed bench: unit A (CLK_DIV=4, MSG_LEN=2) for frame timing and boundaries,
// unit B (CLK_DIV=4, MSG_LEN=8) driven by a simple Com controller loop.
module tb_com_tx_responder;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, a_write = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic       a_txd, a_newcom, a_comend, a_busy, a_overrun;
  logic       rst_b = 1'b1, b_write = 1'b0;
  logic [7:0] b_data = 8'h00;
  logic       b_txd, b_newcom, b_comend, b_busy, b_overrun;

  int checks = 0;
  int errors = 0;
  int writes = 0;

  always #5 clk = ~clk;

  com_tx_responder #(.CLK_DIV(4), .MSG_LEN(2)) u_a (
    .clk(clk), .reset(rst_a), .Write(a_write), .Data(a_data),
    .TxD(a_txd), .NewCom(a_newcom), .ComEnd(a_comend), .Busy(a_busy), .Overrun(a_overrun)
  );

  com_tx_responder #(.CLK_DIV(4), .MSG_LEN(8)) u_b (
    .clk(clk), .reset(rst_b), .Write(b_write), .Data(b_data),
    .TxD(b_txd), .NewCom(b_newcom), .ComEnd(b_comend), .Busy(b_busy), .Overrun(b_overrun)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic fbit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return d[i-1];
  endfunction

  task automatic a_send(input logic [7:0] d);
    a_write = 1'b1; a_data = d;
    tick;
    a_write = 1'b0; a_data = 8'h00;
  endtask

  // Cycle-by-cycle frame check; optionally injects an ignored Write at cycle ovr.
  task automatic a_frame(input logic [7:0] d, input int ovr);
    for (int c = 1; c <= 40; c++) begin
      chk("a_txd", a_txd, fbit(d, (c - 1) / 4));
      chk("a_busy", a_busy, 1);
      chk("a_newcom_low", a_newcom, 0);
      chk("a_overrun", a_overrun, (ovr != 0 && c == ovr + 1));
      a_write = (c == ovr);
      a_data  = (c == ovr) ? 8'h55 : 8'h00;
      tick;
    end
    a_write = 1'b0; a_data = 8'h00;
  endtask

  task automatic b_send(input logic [7:0] d);
    b_write = 1'b1; b_data = d;
    tick;
    b_write = 1'b0; b_data = 8'h00;
    writes++;
  endtask

  // Controller step: send a byte, decode it mid-bit, then wait for the handshake.
  task automatic b_byte(input logic [7:0] d, input logic last);
    logic [7:0] got;
    int n;
    got = 8'h00;
    b_send(d);
    for (int k = 0; k < 10; k++) begin
      repeat (2) tick;
      if (k == 0)      chk("b_start", b_txd, 0);
      else if (k == 9) chk("b_stop", b_txd, 1);
      else             got[k-1] = b_txd;
      repeat (2) tick;
    end
    chk("b_byte", got, d);
    n = 0;
    while (!(b_newcom || b_comend) && n < 20) begin
      tick;
      n++;
    end
    chk("b_handshake_latency", n, 0);
    chk("b_comend", b_comend, last);
    chk("b_newcom", b_newcom, !last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick; tick;
    chk("a_rst_txd", a_txd, 1);
    chk("a_rst_newcom", a_newcom, 0);
    chk("a_rst_comend", a_comend, 0);
    chk("a_rst_busy", a_busy, 0);
    chk("a_rst_overrun", a_overrun, 0);
    chk("b_rst_txd", b_txd, 1);
    rst_a = 1'b0; rst_b = 1'b0;
    tick;

    // A5 frame with an ignored Write 5 cycles in
    a_send(8'hA5);
    a_frame(8'hA5, 5);
    chk("a_newcom_41", a_newcom, 1);
    chk("a_busy_41", a_busy, 0);
    chk("a_comend_41", a_comend, 0);
    chk("a_txd_41", a_txd, 1);

    // Back-to-back Write on the NewCom cycle; Write in the final stop cycle is ignored
    a_send(8'h3C);
    chk("a_newcom_once", a_newcom, 0);
    chk("a_b2b_start", a_txd, 0);
    a_frame(8'h3C, 40);
    chk("a_comend_set", a_comend, 1);
    chk("a_newcom_last", a_newcom, 0);
    chk("a_busy_done", a_busy, 0);
    chk("a_overrun_stop", a_overrun, 1);
    tick;
    chk("a_overrun_clear", a_overrun, 0);
    a_send(8'hFF);
    chk("a_overrun_done", a_overrun, 1);
    chk("a_txd_done", a_txd, 1);
    chk("a_busy_done2", a_busy, 0);
    tick;
    chk("a_overrun_done_clr", a_overrun, 0);
    chk("a_comend_sticky", a_comend, 1);

    // Asynchronous reset in the middle of DATA
    rst_a = 1'b1; tick; rst_a = 1'b0; tick;
    chk("a_rst_clears_comend", a_comend, 0);
    a_send(8'h00);
    repeat (7) tick;
    chk("a_mid_data_txd", a_txd, 0);
    chk("a_mid_data_busy", a_busy, 1);
    rst_a = 1'b1;
    #1;
    chk("a_async_txd", a_txd, 1);
    chk("a_async_busy", a_busy, 0);
    chk("a_async_newcom", a_newcom, 0);
    chk("a_async_comend", a_comend, 0);
    tick; rst_a = 1'b0; tick;
    a_send(8'hA5);
    a_frame(8'hA5, 0);
    chk("a_restart_newcom", a_newcom, 1);
    chk("a_restart_comend", a_comend, 0);

    // Full controller loop on B
    for (int i = 0; i < 8; i++) begin
      b_byte(8'h11 * i[7:0] + 8'h0F, i == 7);
    end
    chk("b_write_count", writes, 8);
    repeat (3) tick;
    chk("b_comend_sticky", b_comend, 1);
    chk("b_txd_idle", b_txd, 1);

    // Reset during stop bit of the third byte, then a full fresh message
    rst_b = 1'b1; tick; rst_b = 1'b0; tick;
    b_byte(8'hC3, 1'b0);
    b_byte(8'h5A, 1'b0);
    b_send(8'h96);
    repeat (37) tick;
    chk("b_stop2_txd", b_txd, 1);
    chk("b_stop2_busy", b_busy, 1);
    rst_b = 1'b1;
    #1;
    chk("b_async_txd", b_txd, 1);
    chk("b_async_busy", b_busy, 0);
    chk("b_async_newcom", b_newcom, 0);
    tick; rst_b = 1'b0; tick;
    for (int i = 0; i < 8; i++) begin
      b_byte(8'hE7 ^ i[7:0], i == 7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
